// File: rtl/jk_sched_pkg.sv
// Shared types and JK cell rule for the JK bank scheduler.
package jk_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } sched_state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic r;
    case ({j, k})
      JK_HOLD: r = q;
      JK_CLR:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TGL:  r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit; qb is its own flop so it is never a cycle behind q.
module jk_cell
  import jk_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic r_q;
  logic r_qb;
  logic w_nxt;

  assign w_nxt = jk_next(j, k, r_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= 1'b0;
      r_qb <= 1'b1;
    end else if (en) begin
      r_q  <= w_nxt;
      r_qb <= ~w_nxt;
    end
  end

  assign q  = r_q;
  assign qb = r_qb;

endmodule

// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler that serialises JK mask writes from N_REQ agents
// into a single W-bit JK bank (grant -> update -> ack, 3 cycles each).
module jk_bank_scheduler
  import jk_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] cmd_j,
  input  logic [N_REQ*W-1:0] cmd_k,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       q,
  output logic [W-1:0]       qb,
  output logic               busy
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [PW:0] NREQ_W = (PW+1)'(N_REQ);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_gnt;
  logic [W-1:0]     r_mask_j;
  logic [W-1:0]     r_mask_k;
  logic [N_REQ-1:0] r_ack;

  logic [2*N_REQ-1:0] w_req2;
  logic [N_REQ-1:0]   w_rot;
  logic               w_any;
  logic [PW-1:0]      w_off;
  logic [PW:0]        w_sum;
  logic [PW:0]        w_diff;
  logic [PW-1:0]      w_win;
  logic [PW:0]        w_inc;
  logic [PW-1:0]      w_ptr_nxt;
  logic [W-1:0]       w_sel_j;
  logic [W-1:0]       w_sel_k;
  logic [N_REQ-1:0]   w_ack_nxt;
  logic               w_grant;
  logic               w_update;
  logic               w_done;

  // Rotate requests so bit 0 is the pointer position, take the lowest set bit,
  // then map the offset back to an absolute requester index.
  assign w_req2 = {req, req} >> r_ptr;
  assign w_rot  = w_req2[N_REQ-1:0];

  always_comb begin
    w_any = |w_rot;
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = PW'(i);
    end
  end

  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_diff = w_sum - NREQ_W;
  assign w_win  = (w_sum >= NREQ_W) ? w_diff[PW-1:0] : w_sum[PW-1:0];

  assign w_inc     = {1'b0, r_gnt} + (PW+1)'(1);
  assign w_ptr_nxt = (w_inc == NREQ_W) ? '0 : w_inc[PW-1:0];

  always_comb begin
    w_sel_j = '0;
    w_sel_k = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == PW'(i)) begin
        w_sel_j = cmd_j[i*W +: W];
        w_sel_k = cmd_k[i*W +: W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_update    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        w_update    = 1'b1;
        w_state_nxt = ACK;
      end
      ACK: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ack_nxt[i] = w_done && (r_gnt == PW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_mask_j <= '0;
      r_mask_k <= '0;
      r_ack    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      if (w_grant) begin
        r_gnt    <= w_win;
        r_mask_j <= w_sel_j;
        r_mask_k <= w_sel_k;
      end
      if (w_done) r_ptr <= w_ptr_nxt;
    end
  end

  for (genvar b = 0; b < W; b++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_update),
      .j     (r_mask_j[b]),
      .k     (r_mask_k[b]),
      .q     (q[b]),
      .qb    (qb[b])
    );
  end

  assign ack  = r_ack;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Self-checking bench: transaction-timeline model plus directed literal checks.
module tb_jk_bank_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] cmd_j;
  logic [N*W-1:0] cmd_k;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [W-1:0]   qb;
  logic           busy;

  int n_chk  = 0;
  int n_pass = 0;

  jk_bank_scheduler #(.N_REQ(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .cmd_j (cmd_j),
    .cmd_k (cmd_k),
    .ack   (ack),
    .q     (q),
    .qb    (qb),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a grant at edge n writes the bank at n+1, acks at n+2 (visible one
  // cycle), and the next grant may happen at n+3.
  int           edge_n = 0;
  int           q_e    = -1;
  int           ack_e  = -1;
  int           free_e = 0;
  int           g_m    = 0;
  int           m_ptr  = 0;
  logic [W-1:0] mq     = '0;
  logic [W-1:0] m_qb   = '1;
  logic [W-1:0] mj     = '0;
  logic [W-1:0] mk     = '0;
  logic [N-1:0] m_ack  = '0;
  logic         m_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq     = '0;
      m_ack  = '0;
      m_busy = 1'b0;
      m_ptr  = 0;
      q_e    = -1;
      ack_e  = -1;
      free_e = edge_n + 1;
    end else begin
      edge_n++;
      m_ack = '0;
      if (edge_n == q_e) mq = (mj & ~mq) | (~mk & mq);
      if (edge_n == ack_e) begin
        m_ack[g_m] = 1'b1;
        m_ptr      = (g_m + 1) % N;
      end
      if (edge_n >= free_e && req != '0) begin
        for (int o = 0; o < N; o++) begin
          if (req[(m_ptr + o) % N]) begin
            g_m = (m_ptr + o) % N;
            break;
          end
        end
        mj     = cmd_j[g_m*W +: W];
        mk     = cmd_k[g_m*W +: W];
        q_e    = edge_n + 1;
        ack_e  = edge_n + 2;
        free_e = edge_n + 3;
      end
      m_busy = (edge_n < ack_e);
    end
    m_qb = ~mq;
  end

  always @(negedge clk) begin
    chk("model_q", q, mq);
    chk("model_qb", qb, m_qb);
    chk("model_ack", ack, m_ack);
    chk("model_busy", busy, m_busy);
  end

  task automatic txn(input int idx, input logic [W-1:0] j, input logic [W-1:0] k,
                     input logic [W-1:0] eq, input logic [N-1:0] eack);
    cmd_j = '0;
    cmd_k = '0;
    cmd_j[idx*W +: W] = j;
    cmd_k[idx*W +: W] = k;
    req = N'(1) << idx;
    @(negedge clk);
    req = '0;
    chk("txn_busy", busy, 1);
    @(negedge clk);
    chk("txn_q", q, eq);
    chk("txn_ack_early", ack, 0);
    @(negedge clk);
    chk("txn_ack", ack, eack);
  endtask

  initial begin
    rst_n = 1'b1;
    req   = '0;
    cmd_j = '0;
    cmd_k = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 8'h00);
    chk("rst_qb", qb, 8'hFF);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(0, 8'h0F, 8'h00, 8'h0F, 4'b0001);
    txn(2, 8'hFF, 8'hFF, 8'hF0, 4'b0100);
    chk("tgl_qb", qb, 8'h0F);
    txn(2, 8'h00, 8'h30, 8'hC0, 4'b0100);

    // pointer now at 3: requester 3 first, then wrap to 0
    cmd_j = '0;
    cmd_k = '0;
    req   = 4'b1001;
    repeat (3) @(negedge clk);
    chk("wrap_ack3", ack, 4'b1000);
    req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("wrap_ack0", ack, 4'b0001);
    req = '0;

    // masks captured at grant; later changes and dropped req are ignored
    cmd_j[15:8] = 8'hAA;
    cmd_k[15:8] = 8'h55;
    req = 4'b0010;
    @(negedge clk);
    cmd_j[15:8] = 8'h55;
    cmd_k[15:8] = 8'hAA;
    req = '0;
    @(negedge clk);
    chk("cap_q", q, 8'hAA);
    @(negedge clk);
    chk("cap_ack", ack, 4'b0010);
    cmd_j = '0;
    cmd_k = '0;

    // reset during GRANT aborts the transaction and the pointer
    cmd_j[23:16] = 8'hFF;
    req = 4'b0100;
    @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_q", q, 8'h00);
    chk("mid_busy", busy, 0);
    chk("mid_ack", ack, 0);
    cmd_j = '0;
    req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req = '0;
    chk("mid_no_ack", ack, 0);
    @(negedge clk);
    chk("mid_q_after", q, 8'h00);
    @(negedge clk);
    chk("mid_rr_from0", ack, 4'b0010);

    // fairness from pointer 0 with all requests held
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c % 3 == 0) chk("rr_ack", ack, 32'(N'(1) << ((c / 3 - 1) % N)));
      else            chk("rr_gap", ack, 0);
    end
    req = '0;
    @(negedge clk);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else begin
        for (int b = 0; b < N; b++) req[b] = ($urandom_range(0, 99) < 35);
        cmd_j = {$urandom, $urandom};
        cmd_k = {$urandom, $urandom};
        if ($urandom_range(0, 99) < 2) begin
          #2 rst_n = 1'b0;
        end
      end
    end
    rst_n = 1'b1;
    req = '0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
